// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   WIDTH-bit register that loads a parallel word or shifts it logically,
//   arithmetically or by rotation. Shifts run in steps of at most STEP bits
//   per clock edge, with a start/busy/done handshake. The first step happens
//   on the edge that accepts the command, so a shift of n steps takes n edges
//   and busy is high for n-1 cycles.
//
// Configuration:
//   USR_ROTATE_EN  defined   -> ops 5/6 perform ROL/ROR.
//                  undefined -> ops 5/6 are illegal (err + done pulse, Q held)
//                               and no rotate logic is built.
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      command strobe, accepted only while busy==0
//   op         in   3      0 NOP, 1 LOAD, 2 SLL, 3 SRL, 4 SRA, 5 ROL, 6 ROR
//   amount     in   AW     shift distance, sampled at accept
//   D          in   WIDTH  parallel load data, sampled at accept
//   serial_in  in   1      fill bit for SLL/SRL, sampled on every step edge
//   Q          out  WIDTH  register contents
//   busy       out  1      high while a multi-step shift is in progress
//   done       out  1      one-cycle pulse when a command completes
//   err        out  1      one-cycle pulse when an illegal op is accepted
// -----------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] D,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_SRL  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
`ifdef USR_ROTATE_EN
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
`endif

    // STEP <= WIDTH-1 always fits in the amount width.
    localparam logic [AW-1:0] STEP_K = AW'(STEP);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] q_next;
    logic [AW-1:0]   remaining;
    logic [AW-1:0]   remaining_next;
    logic [2:0]      op_reg;
    logic [2:0]      op_next;
    logic            done_next;
    logic            err_next;

    logic [AW-1:0]    step_amount;
    logic [2:0]       step_op;
    logic [AW-1:0]    step_k;
    logic [AW-1:0]    rem_after;
    logic [WIDTH-1:0] step_q;
    logic             shift_cmd;

    // One step of k bits. The word is widened to twice its width with the
    // fill (or a copy of itself for rotates) on the vacated side, so the
    // wanted half can be selected after a plain shift.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] val,
        input logic [2:0]       sop,
        input logic [AW-1:0]    k,
        input logic             fill
    );
        logic [WIDTH-1:0] res;
        res = val;
        case (sop)
            OP_SLL:  res = WIDTH'(({val, {WIDTH{fill}}} << k) >> WIDTH);
            OP_SRL:  res = WIDTH'({{WIDTH{fill}}, val} >> k);
            OP_SRA:  res = WIDTH'({{WIDTH{val[WIDTH-1]}}, val} >> k);
`ifdef USR_ROTATE_EN
            OP_ROL:  res = WIDTH'(({val, val} << k) >> WIDTH);
            OP_ROR:  res = WIDTH'({val, val} >> k);
`endif
            default: res = val;
        endcase
        return res;
    endfunction

    // In IDLE the step operates on the command being accepted; in SHIFT it
    // continues the latched command with whatever distance is left.
    always_comb begin
        step_amount = (state == IDLE) ? amount : remaining;
        step_op     = (state == IDLE) ? op : op_reg;
        step_k      = (step_amount < STEP_K) ? step_amount : STEP_K;
        rem_after   = step_amount - step_k;
        step_q      = step_shift(Q, step_op, step_k, serial_in);
    end

    // Which op codes start a shift; rotates only exist when enabled.
    always_comb begin
        shift_cmd = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: shift_cmd = 1'b1;
`ifdef USR_ROTATE_EN
            OP_ROL, OP_ROR:         shift_cmd = 1'b1;
`endif
            default:                shift_cmd = 1'b0;
        endcase
    end

    // Next-state logic. done/err are pulses, so they default low and are
    // raised only on the edge that finishes (or rejects) a command.
    always_comb begin
        state_next     = state;
        q_next         = Q;
        remaining_next = remaining;
        op_next        = op_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_NOP) begin
                        done_next = 1'b1;
                    end else if (op == OP_LOAD) begin
                        q_next    = D;
                        done_next = 1'b1;
                    end else if (shift_cmd) begin
                        op_next = op;
                        q_next  = step_q;
                        if (rem_after == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next     = SHIFT;
                            remaining_next = rem_after;
                        end
                    end else begin
                        err_next  = 1'b1;
                        done_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                q_next         = step_q;
                remaining_next = rem_after;
                if (rem_after == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            Q         <= '0;
            remaining <= '0;
            op_reg    <= OP_NOP;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            Q         <= q_next;
            remaining <= remaining_next;
            op_reg    <= op_next;
            done      <= done_next;
            err       <= err_next;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
//
// Purpose:
//   Self-checking bench for universal_shift_register with WIDTH=8, STEP=2.
//   A table of commands with hand-computed results and step counts is run in
//   sequence (each entry starts from the Q left by the previous one), followed
//   by hand-written sequences for start-while-busy, start in the done cycle
//   and reset in the middle of a shift. Expectations for ops 5/6 follow
//   USR_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int STEP  = 2;
    localparam int AW    = 3;

    logic             clock;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amount;
    logic [WIDTH-1:0] D;
    logic             serial_in;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .amount   (amount),
        .D        (D),
        .serial_in(serial_in),
        .Q        (Q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [2:0]       op;
        logic [AW-1:0]    amount;
        logic [WIDTH-1:0] d;
        logic             sin;
        logic [WIDTH-1:0] exp_q;
        int               exp_n;
        logic             exp_err;
    } vec_t;

    vec_t vectors[16];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: presents a command, lets the next rising edge
    // accept it, and returns at the following falling edge with start low.
    task automatic apply_stimulus(input logic [2:0] c_op, input logic [AW-1:0] c_amt,
                                  input logic [WIDTH-1:0] c_d, input logic c_sin);
        start     = 1'b1;
        op        = c_op;
        amount    = c_amt;
        D         = c_d;
        serial_in = c_sin;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int cycles;
        int busy_cycles;

        vectors[0]  = '{3'd1, 3'd0, 8'hA5, 1'b0, 8'hA5, 1, 1'b0};
        vectors[1]  = '{3'd2, 3'd5, 8'h00, 1'b0, 8'hA0, 3, 1'b0};
        vectors[2]  = '{3'd1, 3'd0, 8'h96, 1'b0, 8'h96, 1, 1'b0};
        vectors[3]  = '{3'd4, 3'd3, 8'h00, 1'b0, 8'hF2, 2, 1'b0};
        vectors[4]  = '{3'd1, 3'd0, 8'h00, 1'b0, 8'h00, 1, 1'b0};
        vectors[5]  = '{3'd3, 3'd7, 8'h00, 1'b1, 8'hFE, 4, 1'b0};
        vectors[6]  = '{3'd2, 3'd0, 8'h00, 1'b0, 8'hFE, 1, 1'b0};
        vectors[7]  = '{3'd2, 3'd3, 8'h00, 1'b1, 8'hF7, 2, 1'b0};
        vectors[8]  = '{3'd3, 3'd1, 8'h00, 1'b0, 8'h7B, 1, 1'b0};
        vectors[9]  = '{3'd0, 3'd4, 8'hFF, 1'b0, 8'h7B, 1, 1'b0};
        vectors[10] = '{3'd1, 3'd0, 8'h3C, 1'b0, 8'h3C, 1, 1'b0};
`ifdef USR_ROTATE_EN
        vectors[11] = '{3'd6, 3'd4, 8'h00, 1'b0, 8'hC3, 2, 1'b0};
        vectors[12] = '{3'd5, 3'd3, 8'h00, 1'b0, 8'h1E, 2, 1'b0};
        vectors[13] = '{3'd7, 3'd2, 8'h55, 1'b0, 8'h1E, 1, 1'b1};
`else
        vectors[11] = '{3'd6, 3'd4, 8'h00, 1'b0, 8'h3C, 1, 1'b1};
        vectors[12] = '{3'd5, 3'd3, 8'h00, 1'b0, 8'h3C, 1, 1'b1};
        vectors[13] = '{3'd7, 3'd2, 8'h55, 1'b0, 8'h3C, 1, 1'b1};
`endif
        vectors[14] = '{3'd1, 3'd0, 8'h81, 1'b0, 8'h81, 1, 1'b0};
        vectors[15] = '{3'd4, 3'd7, 8'h00, 1'b0, 8'hFF, 4, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        amount    = '0;
        D         = '0;
        serial_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_output("reset_q", 32'(Q), 32'h00);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_done", 32'(done), 32'h0);
        check_output("reset_err", 32'(err), 32'h0);

        // Table: each command, its step count, busy length, result and err.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vectors[i].op, vectors[i].amount, vectors[i].d, vectors[i].sin);
            cycles      = 1;
            busy_cycles = 0;
            while (!done && cycles < 16) begin
                if (busy) busy_cycles++;
                @(negedge clock);
                cycles++;
            end
            check_output($sformatf("vec%0d_done", i), 32'(done), 32'h1);
            check_output($sformatf("vec%0d_latency", i), 32'(cycles), 32'(vectors[i].exp_n));
            check_output($sformatf("vec%0d_busy_cycles", i), 32'(busy_cycles),
                         32'(vectors[i].exp_n - 1));
            check_output($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'h0);
            check_output($sformatf("vec%0d_q", i), 32'(Q), 32'(vectors[i].exp_q));
            check_output($sformatf("vec%0d_err", i), 32'(err), 32'(vectors[i].exp_err));
        end

        // start while busy is ignored: the LOAD of FF must never land.
        apply_stimulus(3'd1, 3'd0, 8'hF0, 1'b0);
        apply_stimulus(3'd3, 3'd6, 8'h00, 1'b0);
        check_output("busy_after_accept", 32'(busy), 32'h1);
        start = 1'b1;
        op    = 3'd1;
        D     = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        check_output("busy_mid_shift", 32'(busy), 32'h1);
        @(negedge clock);
        check_output("ignored_start_done", 32'(done), 32'h1);
        check_output("ignored_start_q", 32'(Q), 32'h03);
        @(negedge clock);
        check_output("ignored_start_q_after", 32'(Q), 32'h03);
        check_output("done_single_pulse", 32'(done), 32'h0);

        // start in the done cycle is accepted immediately.
        apply_stimulus(3'd1, 3'd0, 8'h01, 1'b0);
        apply_stimulus(3'd2, 3'd3, 8'h00, 1'b0);
        check_output("sll3_busy", 32'(busy), 32'h1);
        @(negedge clock);
        check_output("sll3_done", 32'(done), 32'h1);
        check_output("sll3_q", 32'(Q), 32'h08);
        apply_stimulus(3'd1, 3'd0, 8'h5A, 1'b0);
        check_output("back_to_back_q", 32'(Q), 32'h5A);
        check_output("back_to_back_done", 32'(done), 32'h1);

        // Reset between edges of a shift clears everything at once.
        apply_stimulus(3'd1, 3'd0, 8'hFF, 1'b0);
        apply_stimulus(3'd2, 3'd7, 8'h00, 1'b0);
        check_output("pre_reset_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_output("async_reset_q", 32'(Q), 32'h00);
        check_output("async_reset_busy", 32'(busy), 32'h0);
        check_output("async_reset_done", 32'(done), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("post_reset_q", 32'(Q), 32'h00);
        check_output("post_reset_busy", 32'(busy), 32'h0);
        check_output("post_reset_done", 32'(done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
